// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the IF refill path and the MEM stage.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN; dbg_state/dbg_starve_cnt expose internal state.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255,
   localparam int SC_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_done,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [2:0]            mem_func3,
   output logic                  mem_done,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [2:0]            bus_func3,
   input  logic                  bus_ready,
   input  logic                  bus_rvalid,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  err,
   output logic [1:0]            dbg_state,
   output logic [SC_W-1:0]       dbg_starve_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  bus_req_q, bus_req_d;
   logic                  bus_we_q, bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic [2:0]            bus_func3_q, bus_func3_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
   logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
   logic                  grant_mem;
   logic                  load_en;
   logic [DATA_WIDTH-1:0] load_val;
   logic                  resp_ok;
   logic                  timeout_hit;

   // Bus handshake: bus_req is held with stable fields until the cycle bus_ready is seen.
   // bus_rvalid completes the access in that same cycle or later (WAIT); outside REQ/WAIT it is ignored.
   assign resp_ok = ((state_q == S_REQ) && bus_ready && bus_rvalid) ||
                    ((state_q == S_WAIT) && bus_rvalid);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      bus_req_d    = 1'b0;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_func3_d  = bus_func3_q;
      starve_cnt_d = starve_cnt_q;
      load_en      = 1'b0;
      load_val     = bus_rdata;
      grant_mem    = mem_req && (!if_req || (starve_cnt_q != SC_W'(STARVE_MAX)));
      unique case (state_q)
         S_IDLE: begin
            if (if_req || mem_req) begin
               state_d   = S_REQ;
               bus_req_d = 1'b1;
               owner_d   = grant_mem;
               if (grant_mem) begin
                  bus_we_d     = mem_we;
                  bus_addr_d   = mem_addr;
                  bus_wdata_d  = mem_wdata;
                  bus_func3_d  = mem_func3;
                  starve_cnt_d = if_req ? starve_cnt_q + 1'b1 : '0;
               end else begin
                  bus_we_d     = 1'b0;
                  bus_addr_d   = if_addr;
                  bus_wdata_d  = '0;
                  bus_func3_d  = 3'b010;
                  starve_cnt_d = '0;
               end
            end
         end
         S_REQ: begin
            if (resp_ok) begin
               load_en = 1'b1;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               load_en  = 1'b1;
               load_val = '0;
               state_d  = S_DONE;
            end else if (bus_ready) begin
               state_d = S_WAIT;
            end else begin
               bus_req_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (resp_ok) begin
               load_en = 1'b1;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               load_en  = 1'b1;
               load_val = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Only the owner's read register moves; the other keeps its last completion.
   always_comb begin
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if (load_en) begin
         if (owner_q) mem_rdata_d = load_val;
         else         if_rdata_d  = load_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_func3_q  <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_func3_q  <= bus_func3_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TC_W = $clog2(TIMEOUT + 1);

   logic [TC_W-1:0] tcnt_q, tcnt_d;
   logic            tout_q, tout_d;

   // tcnt counts cycles spent in REQ/WAIT; the TIMEOUT-th such cycle without a response aborts.
   assign timeout_hit = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                        (tcnt_q == TC_W'(TIMEOUT - 1));

   always_comb begin
      tcnt_d = tcnt_q;
      tout_d = tout_q;
      if (state_q == S_IDLE) begin
         tcnt_d = '0;
         tout_d = 1'b0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
         tcnt_d = tcnt_q + 1'b1;
         tout_d = timeout_hit && !resp_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= '0;
         tout_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tout_q <= tout_d;
      end
   end

   assign err = (state_q == S_DONE) && tout_q;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
   assign err            = 1'b0;
`endif

   assign if_done        = (state_q == S_DONE) && !owner_q;
   assign mem_done       = (state_q == S_DONE) && owner_q;
   assign if_rdata       = if_rdata_q;
   assign mem_rdata      = mem_rdata_q;
   assign stall_if       = if_req & ~if_done;
   assign stall_mem      = mem_req & ~mem_done;
   assign bus_req        = bus_req_q;
   assign bus_we         = bus_we_q;
   assign bus_addr       = bus_addr_q;
   assign bus_wdata      = bus_wdata_q;
   assign bus_func3      = bus_func3_q;
   assign dbg_state      = state_q;
   assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model with a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int SMAX = 4;
`ifdef ARB_TIMEOUT_EN
   localparam int TMO  = 8;
`else
   localparam int TMO  = 255;
`endif
   localparam int SC_W = $clog2(SMAX + 1);
   localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3;

   logic            clk, rst;
   logic            if_req, if_done, mem_req, mem_we, mem_done;
   logic [AW-1:0]   if_addr, mem_addr, bus_addr;
   logic [DW-1:0]   if_rdata, mem_rdata, mem_wdata, bus_wdata, bus_rdata;
   logic [2:0]      mem_func3, bus_func3;
   logic            stall_if, stall_mem, bus_req, bus_we, bus_ready, bus_rvalid, err;
   logic [1:0]      dbg_state;
   logic [SC_W-1:0] dbg_starve_cnt;

   mem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_func3(mem_func3), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_func3(bus_func3), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .err(err), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state: what every observable output must be in the current cycle
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            checking = 1'b0;
   logic [1:0]    exp_state;
   logic          exp_bus_req, exp_if_done, exp_mem_done, exp_err;
   logic          exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_if_rdata, exp_mem_rdata, sb_e;
   logic [2:0]    exp_func3;
   int            model_starve;
   logic [DW-1:0] exp_q[$];
   logic          own;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_state     = ST_IDLE;
      exp_bus_req   = 1'b0;
      exp_if_done   = 1'b0;
      exp_mem_done  = 1'b0;
      exp_err       = 1'b0;
      exp_we        = 1'b0;
      exp_addr      = '0;
      exp_wdata     = '0;
      exp_func3     = '0;
      exp_if_rdata  = '0;
      exp_mem_rdata = '0;
      model_starve  = 0;
   endtask

   // scoreboard / compare process
   always @(negedge clk) begin
      if (checking) begin
         check("state", dbg_state, exp_state);
         check("bus_req", bus_req, exp_bus_req);
         check("if_done", if_done, exp_if_done);
         check("mem_done", mem_done, exp_mem_done);
         check("err", err, exp_err);
         check("stall_if", stall_if, if_req & ~exp_if_done);
         check("stall_mem", stall_mem, mem_req & ~exp_mem_done);
         check("bus_we", bus_we, exp_we);
         check("bus_addr", bus_addr, exp_addr);
         check("bus_wdata", bus_wdata, exp_wdata);
         check("bus_func3", bus_func3, exp_func3);
         check("if_rdata", if_rdata, exp_if_rdata);
         check("mem_rdata", mem_rdata, exp_mem_rdata);
         check("starve_cnt", dbg_starve_cnt, model_starve);
         if (exp_if_done || exp_mem_done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_underflow: got completion, expected none (t=%0t)", $time);
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_rdata", exp_if_done ? if_rdata : mem_rdata, sb_e);
            end
         end
      end
   end

   // Driver: starts in an IDLE cycle with requests already driven (cycle 0).
   // ready_at/rvalid_at are cycle offsets from the grant; rvalid_at == 0 means no response at all.
   task automatic run_txn(input int ready_at, input int rvalid_at, input logic [DW-1:0] rdata,
                          output logic to_mem);
      logic          g_we;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_wdata, exp_rd;
      logic [2:0]    g_func3;
      int            g_starve, done_at;
      bit            timed;
      to_mem = mem_req && (!if_req || model_starve != SMAX);
      if (to_mem) begin
         g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_func3 = mem_func3;
         g_starve = if_req ? model_starve + 1 : 0;
      end else begin
         g_we = 1'b0; g_addr = if_addr; g_wdata = '0; g_func3 = 3'b010;
         g_starve = 0;
      end
      timed   = (rvalid_at == 0);
      done_at = timed ? TMO + 1 : rvalid_at + 1;
      exp_rd  = timed ? '0 : rdata;
      exp_q.push_back(exp_rd);
      for (int c = 1; c <= done_at; c++) begin
         tick();
         if (c == 1) begin
            exp_we = g_we; exp_addr = g_addr; exp_wdata = g_wdata; exp_func3 = g_func3;
            model_starve = g_starve;
         end
         bus_ready  = (c == ready_at);
         bus_rvalid = (c == rvalid_at);
         bus_rdata  = bus_rvalid ? rdata : $urandom;
         if (c == done_at) begin
            exp_state    = ST_DONE;
            exp_bus_req  = 1'b0;
            exp_if_done  = !to_mem;
            exp_mem_done = to_mem;
            exp_err      = timed;
            if (to_mem) exp_mem_rdata = exp_rd;
            else        exp_if_rdata  = exp_rd;
         end else begin
            exp_state   = (ready_at == 0 || c <= ready_at) ? ST_REQ : ST_WAIT;
            exp_bus_req = (exp_state == ST_REQ);
         end
      end
      tick();
      exp_state = ST_IDLE; exp_if_done = 1'b0; exp_mem_done = 1'b0; exp_err = 1'b0;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      if (to_mem) mem_req = 1'b0;
      else        if_req  = 1'b0;
   endtask

   task automatic set_mem(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [2:0] func3);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_func3 = func3;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_func3 = '0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checking = 1'b1;
      tick();
      tick();

      // single load with minimum latency
      set_mem(1'b0, 32'h100, 32'h0, 3'b010);
      run_txn(1, 1, 32'hDEADBEEF, own);
      check("t1_mem_rdata", mem_rdata, 32'hDEADBEEF);

      // collision: MEM first, IF right after
      if_req = 1'b1; if_addr = 32'h2000;
      set_mem(1'b0, 32'h104, 32'h0, 3'b001);
      run_txn(1, 1, 32'h11111111, own);
      check("t2_mem_first", mem_rdata, 32'h11111111);
      check("t2_if_not_yet", if_rdata, 32'h0);
      run_txn(1, 2, 32'h22222222, own);
      check("t2_if_second", if_rdata, 32'h22222222);

      // starvation: MEM re-requests every IDLE while IF waits
      if_req = 1'b1; if_addr = 32'h3000;
      for (int k = 0; k < 5; k++) begin
         set_mem(1'b0, 32'h200 + 32'(4 * k), 32'h0, 3'b010);
         run_txn(1, 1 + (k % 3), 32'hF00D0000 + 32'(k), own);
         if (k < 4) check("t3_mem_grant", mem_rdata, 32'hF00D0000 + 32'(k));
         if (k == 3) check("t3_starve_max", dbg_starve_cnt, 4);
      end
      check("t3_if_grant", if_rdata, 32'hF00D0004);
      check("t3_starve_clr", dbg_starve_cnt, 0);
      run_txn(1, 1, 32'hF00D0005, own);
      check("t3_mem_drain", mem_rdata, 32'hF00D0005);

      // split handshake on a store
      set_mem(1'b1, 32'h300, 32'h55, 3'b010);
      run_txn(3, 7, 32'h0000A5A5, own);
      check("t4_mem_rdata", mem_rdata, 32'h0000A5A5);
      check("t4_if_hold", if_rdata, 32'hF00D0004);

      // IF alone, ready delayed one cycle with same-cycle response
      if_req = 1'b1; if_addr = 32'h4000;
      run_txn(2, 2, 32'hCAFE0007, own);
      check("t7_if_rdata", if_rdata, 32'hCAFE0007);
      check("t7_mem_hold", mem_rdata, 32'h0000A5A5);

      // reset in the middle of WAIT
      set_mem(1'b0, 32'h400, 32'h0, 3'b100);
      tick();
      exp_state = ST_REQ; exp_bus_req = 1'b1;
      exp_we = 1'b0; exp_addr = 32'h400; exp_wdata = 32'h0; exp_func3 = 3'b100;
      model_starve = 0;
      bus_ready = 1'b1;
      tick();
      exp_state = ST_WAIT; exp_bus_req = 1'b0;
      bus_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1; mem_req = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
      tick();
      bus_rvalid = 1'b0;
      check("t5_late_rvalid", mem_rdata, 32'h0);
      check("t5_idle", dbg_state, ST_IDLE);
      tick();

`ifdef ARB_TIMEOUT_EN
      // watchdog: no response at all, then a normal access
      set_mem(1'b0, 32'h500, 32'h0, 3'b010);
      run_txn(1, 1, 32'h12345678, own);
      set_mem(1'b0, 32'h504, 32'h0, 3'b010);
      run_txn(0, 0, 32'hFFFFFFFF, own);
      check("t6_timeout_rdata", mem_rdata, 32'h0);
      set_mem(1'b0, 32'h508, 32'h0, 3'b010);
      run_txn(1, 2, 32'h600DF00D, own);
      check("t6_after_timeout", mem_rdata, 32'h600DF00D);
`endif

      tick();
      check("sb_drained", exp_q.size(), 0);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single data-memory port between the instruction-fetch refill path (IF) and the load/store path of the MEM stage. It sequences each bus transaction through a request/accept/response handshake. It drives per-requester stall signals that freeze the IF/ID and EX/MEM pipeline registers until the access completes. The MEM stage has priority by default, and a starvation counter guarantees IF forward progress.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STARVE_MAX, 4, consecutive MEM grants tolerated while IF waits (≥1)
- TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- if_req  in  1  IF read request; held until if_done
- if_addr  in  ADDR_WIDTH  IF read address
- if_done  out  1  one-cycle completion pulse to IF
- if_rdata  out  DATA_WIDTH  registered read data for IF
- mem_req  in  1  MEM-stage request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_WIDTH  MEM address
- mem_wdata  in  DATA_WIDTH  store data
- mem_func3  in  3  access size/sign code, forwarded unchanged
- mem_done  out  1  one-cycle completion pulse to MEM
- mem_rdata  out  DATA_WIDTH  registered load data for MEM
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  mem_req & ~mem_done (combinational)
- bus_req  out  1  downstream request valid
- bus_we, bus_addr, bus_wdata, bus_func3  out  1/ADDR_WIDTH/DATA_WIDTH/3  latched fields of the winner
- bus_ready  in  1  downstream accepts request this cycle
- bus_rvalid  in  1  downstream response/ack (loads and stores)
- bus_rdata  in  DATA_WIDTH  response data
- err  out  1  one-cycle timeout pulse (0 when macro off)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if either request is asserted, choose a winner. Latch owner, we, addr, wdata, func3 (IF: we=0, wdata=0, func3=3'b010). Go to REQ.
- Winner selection:
  - MEM wins when both requesters are asserting, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each MEM grant made while if_req is high.
  - starve_cnt clears on any IF grant, and on any MEM grant made with if_req low.
- REQ: bus_req=1, with latched fields stable.
  - bus_ready=1 and bus_rvalid=1 in the same cycle: capture data, go to DONE.
  - bus_ready=1 alone: go to WAIT.
- WAIT: bus_req=0. On bus_rvalid, capture bus_rdata into the owner's rdata register (stores also update it), then go to DONE. A bus_rvalid arriving in IDLE or DONE is ignored.
- DONE: pulse the owner's done for exactly one cycle, then go to IDLE. Requests are not sampled in DONE, so the requester can deassert or present a new request, which is sampled in the following IDLE.
- A non-owner's rdata register holds its previous value.
- Reset values: state IDLE; bus_req, if_done, mem_done and err 0; if_rdata, mem_rdata and starve_cnt 0; latched bus fields 0.
- Reset mid-transaction abandons the access with no done pulse. The downstream memory is reset in the same cycle.

## Timing
- Minimum latency:
  - request high in IDLE at cycle 0
  - bus_req high at cycle 1
  - bus_ready & bus_rvalid at cycle 1
  - done at cycle 2
  - IDLE at cycle 3
- Back-to-back throughput: one transaction per 3 cycles at best.
- bus_* outputs are registered. stall_* outputs depend combinationally on req and done.
- done and rdata are valid in the same cycle. rdata holds its value until the next completion for that requester.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter is cleared on entry to REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT without completion: drop bus_req, load 0 into the owner's rdata, pulse err in the DONE cycle together with the owner's done, then go to DONE.
  - A bus_rvalid arriving after the timeout is ignored.
- ARB_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely in REQ/WAIT; err is tied to 0.

## Test plan
- Single load: mem_req=1, mem_addr=0x100, bus_ready=1 and bus_rvalid=1 with bus_rdata=0xDEADBEEF at cycle 1 -> bus_req at cycle 1 only; mem_done and mem_rdata=0xDEADBEEF at cycle 2; stall_mem=1 in cycles 0–1.
- Collision: if_req and mem_req rise together -> MEM granted first, IF granted in the IDLE after mem_done, stall_if held throughout.
- Starvation: if_req held, mem_req re-asserted every IDLE, STARVE_MAX=4 -> exactly 4 MEM grants, then an IF grant, then starve_cnt=0.
- Split handshake: bus_ready at cycle 3, bus_rvalid at cycle 7 on a store (mem_we=1, wdata=0x55) -> bus_req high cycles 1–3, fields stable, mem_done at cycle 8, if_rdata unchanged.
- Reset mid-WAIT: rst at cycle 4 -> cycle 5 shows IDLE, all outputs 0, no done pulse, and a late bus_rvalid is ignored.
- ARB_TIMEOUT_EN with TIMEOUT=8 and no bus_rvalid -> err and mem_done pulse together with mem_rdata=0; the next request proceeds normally.
